cp0_regfile: RTL and testbench

CP0_REGFILE -- requirements
Module: cp0_regfile

---
 rtl/cp0_pkg.sv | 45 ++++
 rtl/cp0_regfile_if.sv | 43 ++++
 rtl/cp0_timer.sv | 68 ++++++
 rtl/cp0_regfile.sv | 185 ++++++++++++++++++
 tb/tb_cp0_regfile.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cp0_pkg.sv
// cp0_pkg
// Shared constants for the CP0 register file:
//   - CP0 register addresses used by mtc0/mfc0
//   - exception codes reported in Cause.ExcCode
//   - bit positions of the Status and Cause fields
//   - is_addr_exc(): true for the address-error codes that capture BadVAddr
package cp0_pkg;

  // CP0 register numbers
  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  // Exception codes. EXC_NONE means that nothing is being reported this cycle.
  typedef enum logic [4:0] {
    EXC_INT  = 5'h00,
    EXC_ADEL = 5'h04,
    EXC_ADES = 5'h05,
    EXC_SYS  = 5'h08,
    EXC_BP   = 5'h09,
    EXC_RI   = 5'h0a,
    EXC_OV   = 5'h0c,
    EXC_NONE = 5'h0f
  } exc_code_e;

  // Status field positions
  localparam int STATUS_IE_BIT  = 0;
  localparam int STATUS_EXL_BIT = 1;
  localparam int STATUS_IM_LSB  = 8;

  // Cause field positions
  localparam int CAUSE_EXC_LSB = 2;
  localparam int CAUSE_IP_LSB  = 8;
  localparam int CAUSE_TI_BIT  = 30;
  localparam int CAUSE_BD_BIT  = 31;

  // Only the load/store address errors carry a meaningful faulting address.
  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_regfile_if.sv
// cp0_regfile_if
// Groups the pipeline <-> CP0 signals.
//   master : pipeline side (drives exception reports, eret, mtc0, mfc0 address,
//            hardware interrupt lines; receives read data and status outputs)
//   slave  : CP0 register file side
// Signals:
//   exc_valid, Exc_BadVaddr, Exc_EPC, Exc_Cause  exception report
//   eret                                         return-from-exception commit
//   mtc0_en, mtc0_addr, mtc0_wdata               register write
//   mfc0_addr, cp0Rdata                          register read
//   hw_int                                       level-sensitive interrupt lines
//   int_req, exc_flush, epc_out, exl             CP0 outputs to the pipeline
interface cp0_regfile_if;

  logic        exc_valid;
  logic [31:0] Exc_BadVaddr;
  logic [31:0] Exc_EPC;
  logic [5:0]  Exc_Cause;
  logic        eret;
  logic        mtc0_en;
  logic [4:0]  mtc0_addr;
  logic [31:0] mtc0_wdata;
  logic [4:0]  mfc0_addr;
  logic [31:0] cp0Rdata;
  logic [5:0]  hw_int;
  logic        int_req;
  logic        exc_flush;
  logic [31:0] epc_out;
  logic        exl;

  modport master (
    output exc_valid, Exc_BadVaddr, Exc_EPC, Exc_Cause, eret,
           mtc0_en, mtc0_addr, mtc0_wdata, mfc0_addr, hw_int,
    input  cp0Rdata, int_req, exc_flush, epc_out, exl
  );

  modport slave (
    input  exc_valid, Exc_BadVaddr, Exc_EPC, Exc_Cause, eret,
           mtc0_en, mtc0_addr, mtc0_wdata, mfc0_addr, hw_int,
    output cp0Rdata, int_req, exc_flush, epc_out, exl
  );

endinterface

// File: rtl/cp0_timer.sv
// cp0_timer
// Count/Compare timer. Count advances once every two clk cycles using a
// one-bit divider toggle and wraps naturally at 32 bits. TI sets when
// Count equals Compare and is cleared by any Compare write.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   count_we_i        write Count with wdata_i (beats the increment)
//   compare_we_i      write Compare with wdata_i (clears TI)
//   wdata_i           write data
//   count_o           current Count
//   compare_o         current Compare
//   ti_o              timer interrupt flag
module cp0_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we_i,
  input  logic        compare_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        ti_o
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        div_q, div_d;
  logic        ti_q, ti_d;

  // Next-state logic: a software Count write overrides the increment; a
  // Compare write clears TI even if the match condition holds this cycle.
  always_comb begin
    div_d     = ~div_q;
    count_d   = count_q;
    compare_d = compare_q;
    ti_d      = ti_q;
    if (count_we_i) begin
      count_d = wdata_i;
    end else if (div_q) begin
      count_d = count_q + 32'd1;
    end
    if (compare_we_i) begin
      compare_d = wdata_i;
      ti_d      = 1'b0;
    end else if (count_q == compare_q) begin
      ti_d = 1'b1;
    end
  end

  // Timer state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q   <= '0;
      compare_q <= '0;
      div_q     <= 1'b0;
      ti_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      div_q     <= div_d;
      ti_q      <= ti_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_regfile.sv
// cp0_regfile
// MIPS-style CP0 register file: BadVAddr, Count, Compare, Status, Cause, EPC.
// Exceptions take priority over eret, which takes priority over mtc0; a
// lower-priority update in the same cycle is dropped.
// Configuration macro: CP0_TIMER_INT_EN enables the Count/Compare timer
// (cp0_timer) and its TI contribution to IP7. Without it Count and Compare
// read 0 and ignore writes.
// Ports:
//   clk   pipeline clock
//   rst   asynchronous active-low reset
//   bus   cp0_regfile_if.slave (exception report, eret, mtc0/mfc0, hw_int,
//         int_req, exc_flush, epc_out, exl)
module cp0_regfile
  import cp0_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  cp0_regfile_if.slave  bus
);

  // Status fields
  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  // Cause fields
  logic        bd_q, bd_d;
  logic [4:0]  excCode_q, excCode_d;
  logic [1:0]  ipSw_q, ipSw_d;
  logic [5:0]  ipHw_q;
  // Other registers
  logic [31:0] epc_q, epc_d;
  logic [31:0] badVaddr_q, badVaddr_d;
  logic        intReq_q, intReq_d;
  logic        excFlush_q;

  logic        excTaken;
  logic        mtc0Write;
  logic [31:0] countVal;
  logic [31:0] compareVal;
  logic        ti;
  logic [7:0]  ipLive;
  logic [7:0]  ipReg;
  logic [31:0] statusRead;
  logic [31:0] causeRead;
  logic [31:0] readData;

  assign excTaken  = bus.exc_valid && (bus.Exc_Cause[4:0] != EXC_NONE);
  // mtc0 only lands when neither an exception nor eret claims this cycle.
  assign mtc0Write = bus.mtc0_en && !excTaken && !bus.eret;

`ifdef CP0_TIMER_INT_EN
  logic countWe;
  logic compareWe;

  assign countWe   = mtc0Write && (bus.mtc0_addr == CP0_COUNT);
  assign compareWe = mtc0Write && (bus.mtc0_addr == CP0_COMPARE);

  cp0_timer u_timer (
    .clk          (clk),
    .rst          (rst),
    .count_we_i   (countWe),
    .compare_we_i (compareWe),
    .wdata_i      (bus.mtc0_wdata),
    .count_o      (countVal),
    .compare_o    (compareVal),
    .ti_o         (ti)
  );
`else
  assign countVal   = '0;
  assign compareVal = '0;
  assign ti         = 1'b0;
`endif

  // Pending vector used for the interrupt request: hardware lines are taken
  // straight from the pins so that int_req rises on the same edge that
  // samples them into Cause.IP.
  assign ipLive = {bus.hw_int[5] | ti, bus.hw_int[4:0], ipSw_q};
  // Pending bits as seen by software through Cause.
  assign ipReg  = {ipHw_q[5] | ti, ipHw_q[4:0], ipSw_q};

  // Register update with exception > eret > mtc0 priority. A nested
  // exception (EXL already set) keeps the original EPC and BD so the first
  // handler's restart point survives.
  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    excCode_d  = excCode_q;
    ipSw_d     = ipSw_q;
    epc_d      = epc_q;
    badVaddr_d = badVaddr_q;
    if (excTaken) begin
      excCode_d = bus.Exc_Cause[4:0];
      exl_d     = 1'b1;
      if (!exl_q) begin
        epc_d = bus.Exc_EPC;
        bd_d  = bus.Exc_Cause[5];
      end
      if (is_addr_exc(bus.Exc_Cause[4:0])) begin
        badVaddr_d = bus.Exc_BadVaddr;
      end
    end else if (bus.eret) begin
      exl_d = 1'b0;
    end else if (mtc0Write) begin
      case (bus.mtc0_addr)
        CP0_STATUS: begin
          im_d  = bus.mtc0_wdata[STATUS_IM_LSB +: 8];
          exl_d = bus.mtc0_wdata[STATUS_EXL_BIT];
          ie_d  = bus.mtc0_wdata[STATUS_IE_BIT];
        end
        CP0_CAUSE: ipSw_d = bus.mtc0_wdata[CAUSE_IP_LSB +: 2];
        CP0_EPC:   epc_d  = bus.mtc0_wdata;
        // BadVAddr is read-only; Count/Compare go to the timer.
        default: ;
      endcase
    end
    intReq_d = ie_q && !exl_q && |(im_q & ipLive);
  end

  // CP0 state registers; reset discards any update pending in this cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      excCode_q  <= '0;
      ipSw_q     <= '0;
      ipHw_q     <= '0;
      epc_q      <= '0;
      badVaddr_q <= '0;
      intReq_q   <= 1'b0;
      excFlush_q <= 1'b0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      excCode_q  <= excCode_d;
      ipSw_q     <= ipSw_d;
      ipHw_q     <= bus.hw_int;
      epc_q      <= epc_d;
      badVaddr_q <= badVaddr_d;
      intReq_q   <= intReq_d;
      excFlush_q <= excTaken;
    end
  end

  // Assemble the architectural views of Status and Cause; unimplemented bits
  // read as zero.
  always_comb begin
    statusRead                        = '0;
    statusRead[STATUS_IM_LSB +: 8]    = im_q;
    statusRead[STATUS_EXL_BIT]        = exl_q;
    statusRead[STATUS_IE_BIT]         = ie_q;
    causeRead                         = '0;
    causeRead[CAUSE_BD_BIT]           = bd_q;
    causeRead[CAUSE_TI_BIT]           = ti;
    causeRead[CAUSE_IP_LSB +: 8]      = ipReg;
    causeRead[CAUSE_EXC_LSB +: 5]     = excCode_q;
  end

  // mfc0 read mux: purely combinational on current register values, so a
  // same-cycle write is not visible until after the edge.
  always_comb begin
    readData = '0;
    case (bus.mfc0_addr)
      CP0_BADVADDR: readData = badVaddr_q;
      CP0_COUNT:    readData = countVal;
      CP0_COMPARE:  readData = compareVal;
      CP0_STATUS:   readData = statusRead;
      CP0_CAUSE:    readData = causeRead;
      CP0_EPC:      readData = epc_q;
      default:      readData = '0;
    endcase
  end

  assign bus.cp0Rdata  = readData;
  assign bus.int_req   = intReq_q;
  assign bus.exc_flush = excFlush_q;
  assign bus.epc_out   = epc_q;
  assign bus.exl       = exl_q;

endmodule

// File: tb/tb_cp0_regfile.sv
// tb_cp0_regfile
// Self-checking bench for cp0_regfile: a table of single-cycle vectors with
// hand-computed results, followed by hand-written sequences for interrupt
// latency, asynchronous reset and (when CP0_TIMER_INT_EN is defined) the timer.
module tb_cp0_regfile;

  localparam logic [31:0] M = 32'hFFFF_FFFF;
  // Cause reads ignore TI and IP7, which the timer may drive in timer builds.
  localparam logic [31:0] C = 32'hBFFF_7FFF;

  typedef struct {
    logic        excValid;
    logic [5:0]  excCause;
    logic [31:0] excEpc;
    logic [31:0] excBadVaddr;
    logic        eret;
    logic        mtc0En;
    logic [4:0]  mtc0Addr;
    logic [31:0] mtc0Wdata;
    logic [4:0]  readAddr;
    logic [31:0] expRdata;
    logic [31:0] rdMask;
    logic        expFlush;
    logic        expExl;
    logic        expIntReq;
    logic [31:0] expEpc;
  } vector_t;

  logic clk;
  logic rst;
  int   checkCount;
  int   failCount;
  vector_t vecs [20];

  cp0_regfile_if cpuBus ();

  cp0_regfile dut (
    .clk (clk),
    .rst (rst),
    .bus (cpuBus)
  );

  // Free-running pipeline clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    cpuBus.exc_valid    = 1'b0;
    cpuBus.Exc_Cause    = 6'h0f;
    cpuBus.Exc_EPC      = '0;
    cpuBus.Exc_BadVaddr = '0;
    cpuBus.eret         = 1'b0;
    cpuBus.mtc0_en      = 1'b0;
    cpuBus.mtc0_addr    = '0;
    cpuBus.mtc0_wdata   = '0;
  endtask

  task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
    idleInputs();
    cpuBus.mtc0_en    = 1'b1;
    cpuBus.mtc0_addr  = addr;
    cpuBus.mtc0_wdata = data;
    tick();
    idleInputs();
  endtask

  // Drive one vector, clock it in, and compare everything it predicts.
  task automatic applyStimulus(input int idx, input vector_t v);
    cpuBus.exc_valid    = v.excValid;
    cpuBus.Exc_Cause    = v.excCause;
    cpuBus.Exc_EPC      = v.excEpc;
    cpuBus.Exc_BadVaddr = v.excBadVaddr;
    cpuBus.eret         = v.eret;
    cpuBus.mtc0_en      = v.mtc0En;
    cpuBus.mtc0_addr    = v.mtc0Addr;
    cpuBus.mtc0_wdata   = v.mtc0Wdata;
    cpuBus.mfc0_addr    = v.readAddr;
    tick();
    checkOutput($sformatf("vec%0d rdata", idx), cpuBus.cp0Rdata & v.rdMask, v.expRdata);
    checkOutput($sformatf("vec%0d exc_flush", idx), {31'b0, cpuBus.exc_flush}, {31'b0, v.expFlush});
    checkOutput($sformatf("vec%0d exl", idx), {31'b0, cpuBus.exl}, {31'b0, v.expExl});
    checkOutput($sformatf("vec%0d int_req", idx), {31'b0, cpuBus.int_req}, {31'b0, v.expIntReq});
    checkOutput($sformatf("vec%0d epc_out", idx), cpuBus.epc_out, v.expEpc);
  endtask

  initial begin
    logic seen;
    checkCount = 0;
    failCount  = 0;

    //          exc   cause  epc            bva            eret  mtc0  addr   wdata          rd     exp            mask flush exl  int   epc
    vecs[0]  = '{1'b0, 6'h0f, 32'h0,         32'h0,         1'b0, 1'b0, 5'd0,  32'h0,         5'd12, 32'h0000_0000, M, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 6'h0f, 32'h0,         32'h0,         1'b0, 1'b0, 5'd0,  32'h0,         5'd14, 32'h0000_0000, M, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 6'h0f, 32'h0,         32'h0,         1'b0, 1'b1, 5'd12, 32'hFFFF_7003, 5'd12, 32'h0000_7003, M, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 6'h0f, 32'h0,         32'h0,         1'b1, 1'b0, 5'd0,  32'h0,         5'd12, 32'h0000_7001, M, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 6'h0f, 32'h0,         32'h0,         1'b0, 1'b1, 5'd14, 32'h1234_5678, 5'd14, 32'h1234_5678, M, 1'b0, 1'b0, 1'b0, 32'h1234_5678};
    vecs[5]  = '{1'b0, 6'h0f, 32'h0,         32'h0,         1'b0, 1'b1, 5'd13, 32'hFFFF_FFFF, 5'd13, 32'h0000_0300, C, 1'b0, 1'b0, 1'b0, 32'h1234_5678};
    vecs[6]  = '{1'b0, 6'h0f, 32'h0,         32'h0,         1'b0, 1'b1, 5'd3,  32'h0000_DEAD, 5'd3,  32'h0000_0000, M, 1'b0, 1'b0, 1'b0, 32'h1234_5678};
    vecs[7]  = '{1'b1, 6'h04, 32'hBFC0_0100, 32'h0000_0013, 1'b0, 1'b0, 5'd0,  32'h0,         5'd13, 32'h0000_0310, C, 1'b1, 1'b1, 1'b0, 32'hBFC0_0100};
    vecs[8]  = '{1'b0, 6'h0f, 32'h0,         32'h0,         1'b0, 1'b0, 5'd0,  32'h0,         5'd8,  32'h0000_0013, M, 1'b0, 1'b1, 1'b0, 32'hBFC0_0100};
    vecs[9]  = '{1'b1, 6'h28, 32'hAAAA_0000, 32'h0000_0055, 1'b0, 1'b0, 5'd0,  32'h0,         5'd13, 32'h0000_0320, C, 1'b1, 1'b1, 1'b0, 32'hBFC0_0100};
    vecs[10] = '{1'b0, 6'h0f, 32'h0,         32'h0,         1'b0, 1'b0, 5'd0,  32'h0,         5'd8,  32'h0000_0013, M, 1'b0, 1'b1, 1'b0, 32'hBFC0_0100};
    vecs[11] = '{1'b0, 6'h0f, 32'h0,         32'h0,         1'b1, 1'b0, 5'd0,  32'h0,         5'd12, 32'h0000_7001, M, 1'b0, 1'b0, 1'b0, 32'hBFC0_0100};
    vecs[12] = '{1'b1, 6'h0c, 32'h8000_0200, 32'h0000_0099, 1'b1, 1'b1, 5'd12, 32'h0000_FF01, 5'd12, 32'h0000_7003, M, 1'b1, 1'b1, 1'b0, 32'h8000_0200};
    vecs[13] = '{1'b0, 6'h0f, 32'h0,         32'h0,         1'b0, 1'b0, 5'd0,  32'h0,         5'd13, 32'h0000_0330, C, 1'b0, 1'b1, 1'b0, 32'h8000_0200};
    vecs[14] = '{1'b1, 6'h0f, 32'h1111_1111, 32'h0000_0066, 1'b0, 1'b0, 5'd0,  32'h0,         5'd13, 32'h0000_0330, C, 1'b0, 1'b1, 1'b0, 32'h8000_0200};
    vecs[15] = '{1'b0, 6'h04, 32'h2222_2222, 32'h0000_0077, 1'b0, 1'b0, 5'd0,  32'h0,         5'd8,  32'h0000_0013, M, 1'b0, 1'b1, 1'b0, 32'h8000_0200};
    vecs[16] = '{1'b1, 6'h25, 32'h3333_3333, 32'h0000_00A5, 1'b0, 1'b0, 5'd0,  32'h0,         5'd8,  32'h0000_00A5, M, 1'b1, 1'b1, 1'b0, 32'h8000_0200};
    vecs[17] = '{1'b0, 6'h0f, 32'h0,         32'h0,         1'b1, 1'b1, 5'd14, 32'hFFFF_FFFF, 5'd14, 32'h8000_0200, M, 1'b0, 1'b0, 1'b0, 32'h8000_0200};
    vecs[18] = '{1'b1, 6'h2a, 32'h0000_4000, 32'h0BAD_0000, 1'b0, 1'b0, 5'd0,  32'h0,         5'd13, 32'h8000_0328, C, 1'b1, 1'b1, 1'b0, 32'h0000_4000};
    vecs[19] = '{1'b0, 6'h0f, 32'h0,         32'h0,         1'b0, 1'b0, 5'd0,  32'h0,         5'd8,  32'h0000_00A5, M, 1'b0, 1'b1, 1'b0, 32'h0000_4000};

    // Reset: hold rst low for a few cycles and check the state while held.
    rst = 1'b0;
    idleInputs();
    cpuBus.hw_int    = '0;
    cpuBus.mfc0_addr = 5'd12;
    repeat (3) tick();
    checkOutput("reset status", cpuBus.cp0Rdata, 32'h0);
    checkOutput("reset exc_flush", {31'b0, cpuBus.exc_flush}, 32'h0);
    rst = 1'b1;

    $display("[TB] running %0d table vectors", 20);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(i, vecs[i]);
    end
    idleInputs();

    // Interrupt request latency: one cycle to assert, one cycle after EXL.
    $display("[TB] interrupt latency sequence");
    cpuBus.eret = 1'b1;
    tick();
    idleInputs();
    mtc0(5'd12, 32'h0000_0401);
    checkOutput("int idle", {31'b0, cpuBus.int_req}, 32'h0);
    cpuBus.hw_int = 6'b000001;
    tick();
    checkOutput("int assert", {31'b0, cpuBus.int_req}, 32'h1);
    cpuBus.mfc0_addr = 5'd13;
    #1;
    checkOutput("cause IP2", cpuBus.cp0Rdata & 32'h0000_7C00, 32'h0000_0400);
    mtc0(5'd12, 32'h0000_0403);
    checkOutput("exl via mtc0", {31'b0, cpuBus.exl}, 32'h1);
    tick();
    checkOutput("int masked by exl", {31'b0, cpuBus.int_req}, 32'h0);
    cpuBus.hw_int = '0;

`ifndef CP0_TIMER_INT_EN
    // Without the timer, Count/Compare ignore writes and read zero.
    mtc0(5'd9, 32'h0000_0007);
    cpuBus.mfc0_addr = 5'd9;
    #1;
    checkOutput("count disabled", cpuBus.cp0Rdata, 32'h0);
    mtc0(5'd11, 32'h0000_0005);
    cpuBus.mfc0_addr = 5'd11;
    #1;
    checkOutput("compare disabled", cpuBus.cp0Rdata, 32'h0);
`else
    // Timer: Compare=5, Count=0, wait for TI then the interrupt.
    $display("[TB] timer sequence");
    mtc0(5'd12, 32'h0000_8001);
    mtc0(5'd11, 32'h0000_0005);
    mtc0(5'd9, 32'h0000_0000);
    cpuBus.mfc0_addr = 5'd13;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      tick();
      seen = cpuBus.cp0Rdata[30];
    end
    checkOutput("timer TI set", {31'b0, seen}, 32'h1);
    seen = 1'b0;
    for (int n = 0; n < 5 && !seen; n++) begin
      tick();
      seen = cpuBus.int_req;
    end
    checkOutput("timer int_req", {31'b0, seen}, 32'h1);
    mtc0(5'd11, 32'h0000_1000);
    cpuBus.mfc0_addr = 5'd13;
    #1;
    checkOutput("timer TI cleared", {31'b0, cpuBus.cp0Rdata[30]}, 32'h0);
    mtc0(5'd9, 32'hFFFF_FFFF);
`endif

    // Asynchronous reset in the middle of an exception.
    $display("[TB] asynchronous reset sequence");
    mtc0(5'd12, 32'h0000_0001);
    cpuBus.exc_valid    = 1'b1;
    cpuBus.Exc_Cause    = 6'h04;
    cpuBus.Exc_EPC      = 32'hCAFE_0000;
    cpuBus.Exc_BadVaddr = 32'h0000_0044;
    tick();
    checkOutput("pre-reset flush", {31'b0, cpuBus.exc_flush}, 32'h1);
    cpuBus.mfc0_addr = 5'd12;
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async rst flush", {31'b0, cpuBus.exc_flush}, 32'h0);
    checkOutput("async rst status", cpuBus.cp0Rdata, 32'h0);
    checkOutput("async rst epc", cpuBus.epc_out, 32'h0);
    checkOutput("async rst exl", {31'b0, cpuBus.exl}, 32'h0);
    cpuBus.mfc0_addr = 5'd9;
    #1;
    checkOutput("async rst count", cpuBus.cp0Rdata, 32'h0);
    cpuBus.mfc0_addr = 5'd8;
    #1;
    checkOutput("async rst badvaddr", cpuBus.cp0Rdata, 32'h0);
    cpuBus.mfc0_addr = 5'd13;
    #1;
    checkOutput("async rst cause", cpuBus.cp0Rdata, 32'h0);
    // Pending exception keeps being reported while reset is held.
    tick();
    tick();
    checkOutput("held rst epc", cpuBus.epc_out, 32'h0);
    checkOutput("held rst flush", {31'b0, cpuBus.exc_flush}, 32'h0);
    idleInputs();
    rst = 1'b1;
    mtc0(5'd14, 32'h0000_5A5A);
    checkOutput("post-reset epc write", cpuBus.epc_out, 32'h0000_5A5A);
    checkOutput("post-reset int_req", {31'b0, cpuBus.int_req}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
